// File: rtl/fir_feeder_pkg.sv
// Shared definitions for the FIR sample feeder: FSM encoding and derived widths.
package fir_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Checksum holds up to 2^addr_w results of out_w bits without overflow.
  function automatic int checksum_width(input int out_w, input int addr_w);
    return out_w + addr_w + 1;
  endfunction

endpackage

// File: rtl/fir_sample_ram.sv
// Sample store: synchronous write, asynchronous read, contents not reset.
module fir_sample_ram #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fir_sample_feeder.sv
// Issues a block of stored samples to the serial FIR filter one at a time,
// captures each result with its index and accumulates a checksum.
module fir_sample_feeder
  import fir_feeder_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 22,
  parameter int DEPTH     = 128,
  parameter int ADDR_W    = 7,
  parameter int TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     start,
  input  logic [ADDR_W:0]          num_samples,
  output logic [WIDTH-1:0]         fir_input,
  output logic                     input_valid,
  input  logic                     output_valid,
  input  logic [OUT_WIDTH-1:0]     fir_output,
  output logic                     res_valid,
  output logic [OUT_WIDTH-1:0]     res_data,
  output logic [ADDR_W-1:0]        res_index,
  output logic [OUT_WIDTH+ADDR_W:0] checksum,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  output logic                     spurious_err,
  output state_e                   dbg_state
);

  localparam int CSUM_W  = checksum_width(OUT_WIDTH, ADDR_W);
  localparam int TIMER_W = $clog2(TIMEOUT + 1);

  // Handshake: input_valid is a one-cycle strobe with fir_input stable for
  // that cycle; the filter answers with a one-cycle output_valid, which is
  // only accepted in WAIT. There is no backpressure in either direction.

  state_e              state;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W:0]     n_samp;
  logic [TIMER_W-1:0]  timer;
  logic [ADDR_W:0]     n_clamped;
  logic                last_sample;
  logic [ADDR_W-1:0]   rd_addr;
  logic [WIDTH-1:0]    rd_data;
  logic                ram_we;

  assign input_valid = (state == ISSUE);
  assign busy        = (state != IDLE);
  assign dbg_state   = state;
  assign ram_we      = wr_en && (state == IDLE);

  always_comb begin
    n_clamped   = num_samples;
    if (num_samples > (ADDR_W+1)'(DEPTH)) n_clamped = (ADDR_W+1)'(DEPTH);
    last_sample = (({1'b0, idx} + (ADDR_W+1)'(1)) == n_samp);
    // In IDLE the read port presents sample 0 for the start load;
    // otherwise it looks one ahead for the next reload.
    rd_addr     = (state == IDLE) ? '0 : idx + ADDR_W'(1);
  end

  fir_sample_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      idx          <= '0;
      n_samp       <= '0;
      timer        <= '0;
      fir_input    <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_index    <= '0;
      checksum     <= '0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      spurious_err <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            timeout_err  <= 1'b0;
            spurious_err <= 1'b0;
            if (num_samples != '0) begin
              n_samp    <= n_clamped;
              idx       <= '0;
              checksum  <= '0;
              fir_input <= rd_data;
              state     <= ISSUE;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + TIMER_W'(1);
          // A result arriving on the final WAIT cycle beats the timeout.
          if (output_valid) begin
            res_data  <= fir_output;
            res_index <= idx;
            res_valid <= 1'b1;
            checksum  <= checksum + CSUM_W'(fir_output);
            if (last_sample) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx       <= idx + ADDR_W'(1);
              fir_input <= rd_data;
              state     <= ISSUE;
            end
          end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (output_valid && (state != WAIT)) spurious_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Randomized bench for fir_sample_feeder with a transaction-level model,
// a filter responder and directed boundary cases.
module tb_fir_sample_feeder;

  localparam int WIDTH     = 8;
  localparam int OUT_WIDTH = 22;
  localparam int DEPTH     = 128;
  localparam int ADDR_W    = 7;
  localparam int TIMEOUT   = 255;
  localparam int CS_W      = OUT_WIDTH + ADDR_W + 1;

  // ---------------- clock / reset / DUT ----------------
  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 wr_en = 1'b0;
  logic [ADDR_W-1:0]    wr_addr = '0;
  logic [WIDTH-1:0]     wr_data = '0;
  logic                 start = 1'b0;
  logic [ADDR_W:0]      num_samples = '0;
  logic [WIDTH-1:0]     fir_input;
  logic                 input_valid;
  logic                 output_valid = 1'b0;
  logic [OUT_WIDTH-1:0] fir_output = '0;
  logic                 res_valid;
  logic [OUT_WIDTH-1:0] res_data;
  logic [ADDR_W-1:0]    res_index;
  logic [CS_W-1:0]      checksum;
  logic                 busy;
  logic                 done;
  logic                 timeout_err;
  logic                 spurious_err;
  fir_feeder_pkg::state_e dbg_state;

  always #5 clk = ~clk;

  fir_sample_feeder #(
    .WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH), .DEPTH(DEPTH),
    .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .num_samples(num_samples), .fir_input(fir_input),
    .input_valid(input_valid), .output_valid(output_valid), .fir_output(fir_output),
    .res_valid(res_valid), .res_data(res_data), .res_index(res_index),
    .checksum(checksum), .busy(busy), .done(done), .timeout_err(timeout_err),
    .spurious_err(spurious_err), .dbg_state(dbg_state)
  );

  // ---------------- model state ----------------
  logic [WIDTH-1:0]     model_mem [DEPTH];
  logic [WIDTH-1:0]     exp_sample_q[$];
  logic [OUT_WIDTH-1:0] exp_data_q[$];
  logic [ADDR_W-1:0]    exp_idx_q[$];
  logic [CS_W-1:0]      model_sum = '0;
  bit                   exp_timeout = 0;

  int pass_cnt = 0, total_cnt = 0;
  int cyc = 0, iv_cnt = 0, rv_cnt = 0, done_cnt = 0;
  int last_iv_cyc = 0, last_done_cyc = 0;

  // responder controls
  bit                   resp_on = 1, resp_mul10 = 0, force_ov = 0;
  int                   resp_fixed = 3, resp_max = 4;
  logic [OUT_WIDTH-1:0] force_val = '0;
  int                   resp_idx = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- filter responder ----------------
  initial begin : responder
    bit pend = 0;
    int cd = 0;
    logic [OUT_WIDTH-1:0] resp_val = '0;
    forever begin
      @(negedge clk);
      output_valid = 1'b0;
      fir_output   = '0;
      if (!rst) pend = 0;
      else if (force_ov) begin
        output_valid = 1'b1;
        fir_output   = force_val;
        force_ov     = 0;
      end else if (pend) begin
        if (cd == 0) begin
          output_valid = 1'b1;
          fir_output   = resp_val;
          exp_data_q.push_back(resp_val);
          exp_idx_q.push_back(ADDR_W'(resp_idx));
          model_sum += CS_W'(resp_val);
          resp_idx++;
          pend = 0;
        end else cd--;
      end
      if (rst && input_valid && resp_on) begin
        pend     = 1;
        cd       = ((resp_fixed > 0) ? resp_fixed : $urandom_range(1, resp_max)) - 1;
        resp_val = resp_mul10 ? OUT_WIDTH'(10 * model_mem[resp_idx]) : OUT_WIDTH'($urandom);
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (input_valid) begin
        iv_cnt++;
        last_iv_cyc = cyc;
        check("busy with input_valid", busy, 1);
        if (exp_sample_q.size() == 0) check("unexpected input_valid", 1, 0);
        else check("fir_input", fir_input, exp_sample_q.pop_front());
      end
      if (res_valid) begin
        rv_cnt++;
        if (exp_data_q.size() == 0) check("unexpected res_valid", 1, 0);
        else begin
          check("res_data", res_data, exp_data_q.pop_front());
          check("res_index", res_index, exp_idx_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
        check("checksum at done", checksum, model_sum);
        check("timeout_err at done", timeout_err, exp_timeout);
        check("samples left at done", exp_sample_q.size(), 0);
        check("results left at done", exp_data_q.size(), 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_mem(input int addr, input int data, input bit accept);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(addr);
    wr_data = WIDTH'(data);
    if (accept) model_mem[addr] = WIDTH'(data);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_start(input int n, input bit accept);
    @(negedge clk);
    start       = 1'b1;
    num_samples = (ADDR_W+1)'(n);
    if (accept && n > 0) begin
      int eff = (n > DEPTH) ? DEPTH : n;
      exp_sample_q.delete();
      for (int i = 0; i < eff; i++) exp_sample_q.push_back(model_mem[i]);
      model_sum = '0;
      resp_idx  = 0;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int base = done_cnt;
    int i = 0;
    while (done_cnt == base && i < budget) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (done_cnt == base) check("done within cycle budget", 0, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " fir_input"}, fir_input, 0);
    check({tag, " input_valid"}, input_valid, 0);
    check({tag, " res_valid"}, res_valid, 0);
    check({tag, " res_data"}, res_data, 0);
    check({tag, " res_index"}, res_index, 0);
    check({tag, " checksum"}, checksum, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " timeout_err"}, timeout_err, 0);
    check({tag, " spurious_err"}, spurious_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int iv0, rv0, d0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // basic run: samples 1..4, filter answers 10*sample after 3 cycles
    for (int i = 0; i < 4; i++) write_mem(i, i + 1, 1);
    resp_mul10 = 1; resp_fixed = 3;
    iv0 = iv_cnt; rv0 = rv_cnt; d0 = done_cnt;
    do_start(4, 1);
    wait_done(200);
    check("basic input_valid count", iv_cnt - iv0, 4);
    check("basic res_valid count", rv_cnt - rv0, 4);
    check("basic done count", done_cnt - d0, 1);
    check("basic checksum literal", checksum, 100);
    check("basic last res_data literal", res_data, 40);
    check("basic last res_index literal", res_index, 3);
    check("basic spurious_err", spurious_err, 0);
    @(negedge clk); #1;
    check("done is one cycle", done, 0);
    check("idle after run", busy, 0);

    // N=0: done one cycle after start, nothing issued
    iv0 = iv_cnt;
    do_start(0, 1);
    #1;
    check("N=0 done next cycle", done, 1);
    check("N=0 busy", busy, 0);
    @(negedge clk); #1;
    check("N=0 done cleared", done, 0);
    check("N=0 busy after", busy, 0);
    check("N=0 no input_valid", iv_cnt - iv0, 0);

    // filter never answers: timeout
    resp_on = 0; exp_timeout = 1;
    iv0 = iv_cnt; rv0 = rv_cnt;
    do_start(1, 1);
    wait_done(400);
    check("timeout done latency", last_done_cyc - last_iv_cyc, 256);
    check("timeout_err set", timeout_err, 1);
    check("timeout single input_valid", iv_cnt - iv0, 1);
    check("timeout no res_valid", rv_cnt - rv0, 0);

    // answer on the very last WAIT cycle: captured, no error
    resp_on = 1; exp_timeout = 0; resp_fixed = TIMEOUT;
    rv0 = rv_cnt;
    do_start(1, 1);
    #1;
    check("timeout_err cleared by start", timeout_err, 0);
    wait_done(400);
    check("edge capture res_valid", rv_cnt - rv0, 1);
    check("edge capture timeout_err", timeout_err, 0);
    check("edge capture latency", last_done_cyc - last_iv_cyc, 256);

    // spurious output_valid, writes and start while busy
    resp_mul10 = 0; resp_fixed = 4;
    rv0 = rv_cnt;
    @(negedge clk); #1;
    force_ov = 1; force_val = 22'd123;
    repeat (2) @(negedge clk);
    #1;
    check("spurious_err in IDLE", spurious_err, 1);
    check("spurious no capture", rv_cnt - rv0, 0);
    iv0 = iv_cnt;
    do_start(3, 1);
    #1;
    check("spurious cleared by start", spurious_err, 0);
    write_mem(2, int'(model_mem[2] ^ 8'hFF), 0);
    do_start(4, 0);
    wait_done(300);
    check("busy start ignored", iv_cnt - iv0, 3);
    check("busy spurious_err", spurious_err, 0);
    @(negedge clk); #1;
    force_ov = 1; force_val = 22'd7;
    repeat (2) @(negedge clk);
    #1;
    check("spurious_err again", spurious_err, 1);
    do_start(4, 1);
    #1;
    check("spurious cleared again", spurious_err, 0);
    wait_done(300);

    // fill the whole memory with random data
    for (int i = 0; i < DEPTH; i++) write_mem(i, int'($urandom_range(0, 255)), 1);

    // mid-run reset during WAIT of sample index 1 (second of five)
    iv0 = iv_cnt; d0 = done_cnt;
    do_start(5, 1);
    for (int i = 0; i < 100 && iv_cnt < iv0 + 2; i++) begin
      @(negedge clk);
      #1;
    end
    check("reached second sample", iv_cnt - iv0, 2);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_zero("mid-run reset");
    exp_sample_q.delete(); exp_data_q.delete(); exp_idx_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("no done after reset", done_cnt - d0, 0);
    iv0 = iv_cnt; rv0 = rv_cnt;
    do_start(5, 1);
    wait_done(300);
    check("replay input_valid count", iv_cnt - iv0, 5);
    check("replay res_valid count", rv_cnt - rv0, 5);

    // randomized runs
    for (int r = 0; r < 15; r++) begin
      for (int w = 0; w < 2; w++)
        write_mem(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), 1);
      resp_fixed = 0;
      resp_max   = $urandom_range(1, 8);
      resp_mul10 = 1'($urandom_range(0, 1));
      iv0 = iv_cnt;
      begin
        int n = $urandom_range(1, 12);
        do_start(n, 1);
        wait_done(2000);
        check("random run issue count", iv_cnt - iv0, n);
      end
    end

    // num_samples above DEPTH is clamped
    resp_fixed = 1;
    iv0 = iv_cnt;
    do_start(200, 1);
    wait_done(2000);
    check("clamped issue count", iv_cnt - iv0, DEPTH);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
